// File: rtl/polyz_unpack_stream.sv
// Purpose: decode z polynomial packing, 5 packed bytes -> 2 signed 32-bit coefficients (GAMMA1 - t).
// Latency: out_valid rises the cycle after the 5th byte of a group; best case 7 cycles per pair.
// Backpressure: in_ready low while emitting; out_* hold while out_valid && !out_ready.
module polyz_unpack_stream #(
  parameter int GAMMA1 = 524288,
  parameter int N      = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_coeff,
  output logic [7:0]  out_idx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_last
);

  typedef enum logic [1:0] {COLLECT, EMIT0, EMIT1} state_t;

  localparam logic [31:0] GAMMA1_W  = 32'(GAMMA1);
  localparam logic [7:0]  LAST_IDX  = 8'(N - 1);

  state_t      state_q, state_d;
  logic [2:0]  byte_cnt_q, byte_cnt_d;
  logic [7:0]  coeff_cnt_q, coeff_cnt_d;
  logic [39:0] grp_q, grp_d;
  logic [19:0] t0, t1;

  // Byte slot k of the group sits at bits [8k+7:8k], so both fields are plain slices.
  assign t0 = grp_q[19:0];
  assign t1 = grp_q[39:20];

  // State, counters and group register; reset discards any partial group or pending pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= COLLECT;
      byte_cnt_q  <= 3'd0;
      coeff_cnt_q <= 8'd0;
      grp_q       <= 40'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      coeff_cnt_q <= coeff_cnt_d;
      grp_q       <= grp_d;
    end
  end

  // Next-state and output decode; outputs are zero whenever out_valid is low.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    coeff_cnt_d = coeff_cnt_q;
    grp_d       = grp_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_coeff   = 32'd0;
    out_idx     = 8'd0;
    out_last    = 1'b0;

    case (state_q)
      COLLECT: begin
        in_ready = 1'b1;
        if (in_valid) begin
          for (int i = 0; i < 5; i++) begin
            if (byte_cnt_q == 3'(i)) grp_d[i*8 +: 8] = in_data;
          end
          if (byte_cnt_q == 3'd4) begin
            byte_cnt_d = 3'd0;
            state_d    = EMIT0;
          end else begin
            byte_cnt_d = byte_cnt_q + 3'd1;
          end
        end
      end

      EMIT0: begin
        out_valid = 1'b1;
        out_coeff = GAMMA1_W - {12'd0, t0};
        out_idx   = coeff_cnt_q;
        if (out_ready) begin
          coeff_cnt_d = coeff_cnt_q + 8'd1;
          state_d     = EMIT1;
        end
      end

      EMIT1: begin
        out_valid = 1'b1;
        out_coeff = GAMMA1_W - {12'd0, t1};
        out_idx   = coeff_cnt_q;
        out_last  = (coeff_cnt_q == LAST_IDX);
        if (out_ready) begin
          // 8-bit counter wraps 255 -> 0, which starts the next polynomial.
          coeff_cnt_d = coeff_cnt_q + 8'd1;
          state_d     = COLLECT;
        end
      end

      default: state_d = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_polyz_unpack_stream.sv
module tb_polyz_unpack_stream;

  localparam int GAMMA1 = 524288;

  logic        clk;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_coeff;
  logic [7:0]  out_idx;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;

  int tests;
  int fails;

  // Reference model state: bytes still to send, coefficients still expected, next index.
  logic [7:0]  byte_q[$];
  logic [31:0] exp_q[$];
  int          exp_idx;

  typedef struct {
    logic [39:0] bytes;  // b0 in [7:0] ... b4 in [39:32]
    logic [31:0] c0;
    logic [31:0] c1;
  } vec_t;

  polyz_unpack_stream dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_coeff (out_coeff),
    .out_idx   (out_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  // Pack a coefficient pair the way the encoder does: t = GAMMA1 - c, 20 bits each.
  task automatic push_pair(input int c0, input int c1);
    logic [19:0] t0, t1;
    t0 = 20'(GAMMA1 - c0);
    t1 = 20'(GAMMA1 - c1);
    byte_q.push_back(t0[7:0]);
    byte_q.push_back(t0[15:8]);
    byte_q.push_back({t1[3:0], t0[19:16]});
    byte_q.push_back(t1[11:4]);
    byte_q.push_back(t1[19:12]);
    exp_q.push_back(32'(c0));
    exp_q.push_back(32'(c1));
  endtask

  task automatic push_group(input logic [39:0] g);
    for (int i = 0; i < 5; i++) byte_q.push_back(g[i*8 +: 8]);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    byte_q.delete();
    exp_q.delete();
    exp_idx = 0;
  endtask

  // Drive queued bytes with given in_valid / out_ready duty (%) and score every output transfer.
  task automatic run(input int iv_pct, input int or_pct, input int budget);
    int          cyc;
    logic        hold_v;
    logic [31:0] hold_c;
    logic [7:0]  hold_i;
    logic        hold_l;
    cyc = 0;
    hold_v = 1'b0;
    hold_c = '0; hold_i = '0; hold_l = 1'b0;
    while ((byte_q.size() > 0 || exp_q.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      in_valid  = (byte_q.size() > 0) && ($urandom_range(99) < iv_pct);
      in_data   = in_valid ? byte_q[0] : 8'($urandom);
      out_ready = ($urandom_range(99) < or_pct);
      if (hold_v) begin
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_coeff", out_coeff, hold_c);
        chk("stall_idx", {24'd0, out_idx}, {24'd0, hold_i});
        chk("stall_last", {31'd0, out_last}, {31'd0, hold_l});
      end
      if (out_valid) chk("in_ready_emit", {31'd0, in_ready}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_coeff", {31'd0, out_valid}, 32'd0);
        end else begin
          chk("coeff", out_coeff, exp_q[0]);
          chk("idx", {24'd0, out_idx}, 32'(exp_idx));
          chk("last", {31'd0, out_last}, {31'd0, exp_idx == 255});
          void'(exp_q.pop_front());
          exp_idx = (exp_idx + 1) % 256;
        end
      end
      if (in_valid && in_ready) void'(byte_q.pop_front());
      hold_v = out_valid && !out_ready;
      hold_c = out_coeff; hold_i = out_idx; hold_l = out_last;
    end
    if (cyc >= budget) begin
      chk("run_timeout", 32'(exp_q.size()), 32'd0);
      byte_q.delete();
      exp_q.delete();
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("idle_after_run", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic feed_manual(input logic [39:0] g, input int nbytes);
    for (int i = 0; i < nbytes; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = g[i*8 +: 8];
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  vec_t vecs[5];

  initial begin
    tests = 0; fails = 0; exp_idx = 0;
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b0;

    vecs[0] = '{40'h00_00_00_00_00, 32'h0008_0000, 32'h0008_0000};
    vecs[1] = '{40'h80_00_08_00_00, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{40'hFF_FF_FF_FF_FF, 32'hFFF8_0001, 32'hFFF8_0001};
    vecs[3] = '{40'h00_00_10_00_01, 32'h0007_FFFF, 32'h0007_FFFF};
    vecs[4] = '{40'hFF_FF_F0_00_00, 32'h0008_0000, 32'hFFF8_0001};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_coeff", out_coeff, 32'd0);
    chk("rst_out_idx", {24'd0, out_idx}, 32'd0);
    chk("rst_out_last", {31'd0, out_last}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Table-driven groups at full rate
    for (int v = 0; v < 5; v++) begin
      push_group(vecs[v].bytes);
      exp_q.push_back(vecs[v].c0);
      exp_q.push_back(vecs[v].c1);
      run(100, 100, 100);
    end

    // Two back-to-back random polynomials, full rate, then two with gaps and stalls
    do_reset();
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 128; k++)
        push_pair(int'($urandom_range(1048575)) - 524287, int'($urandom_range(1048575)) - 524287);
    run(100, 100, 5000);
    chk("poly_idx_wrap", 32'(exp_idx), 32'd0);
    for (int p = 0; p < 2; p++)
      for (int k = 0; k < 128; k++)
        push_pair(int'($urandom_range(1048575)) - 524287, int'($urandom_range(1048575)) - 524287);
    run(70, 50, 20000);
    chk("poly_idx_wrap_stall", 32'(exp_idx), 32'd0);

    // in_valid low mid-group: partial group must survive a long gap
    push_group(vecs[3].bytes);
    exp_q.push_back(vecs[3].c0);
    exp_q.push_back(vecs[3].c1);
    run(15, 100, 2000);

    // Reset after 3 bytes of a group
    do_reset();
    feed_manual(40'hFF_FF_FF_FF_FF, 3);
    chk("part_no_valid", {31'd0, out_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_idx = 0;
    push_group(vecs[1].bytes);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    run(100, 100, 100);

    // Reset during a stalled EMIT1
    do_reset();
    feed_manual(40'h00_00_10_00_01, 5);
    chk("emit0_valid", {31'd0, out_valid}, 32'd1);
    chk("emit0_idx", {24'd0, out_idx}, 32'd0);
    chk("emit0_coeff", out_coeff, 32'h0007_FFFF);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("emit1_valid", {31'd0, out_valid}, 32'd1);
    chk("emit1_idx", {24'd0, out_idx}, 32'd1);
    @(negedge clk);
    chk("emit1_stall_valid", {31'd0, out_valid}, 32'd1);
    chk("emit1_stall_in_ready", {31'd0, in_ready}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_emit_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_emit_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    exp_idx = 0;
    push_group(vecs[1].bytes);
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd0);
    run(100, 100, 100);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/polyz_unpack_stream.md
Name: polyz_unpack_stream

Overview:
- Streaming decoder for the 20-bit-per-coefficient z polynomial packing: 640-byte input, 256 signed coefficients out.
- Accepts packed bytes one per handshake, LSB-first. Every 5-byte group yields coefficient pairs, computed as GAMMA1 minus each 20-bit field.
- Sits between the signature byte buffer and the verify-side NTT/norm-check path.

Parameters:
- GAMMA1, 524288 (2^19): centring offset subtracted from, per coefficient.
- N, 256: coefficients per polynomial. Fixed bytes per polynomial = 5*N/2 = 640.

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  packed byte
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a byte this cycle
- out_coeff  output  32  decoded coefficient, signed two's complement
- out_idx  output  8  coefficient index 0..255 within current polynomial
- out_valid  output  1  out_coeff/out_idx/out_last valid
- out_ready  input  1  downstream accepts coefficient
- out_last  output  1  high with coefficient 255 of a polynomial

Behaviour:
- Reset (async assert, active-high): state=COLLECT, byte_cnt=0, coeff_cnt=0, 40-bit group register cleared.
- Output reset values: in_ready=1 once rst deasserts (combinational from state). out_valid=0, out_coeff=0, out_idx=0, out_last=0.
- Handshakes:
  - Byte transfer on in_valid&in_ready. Coefficient transfer on out_valid&out_ready.
  - out_* held stable while out_valid&!out_ready.
  - in_ready does not depend on in_valid.
- FSM states: COLLECT, EMIT0, EMIT1.
  - COLLECT: in_ready=1, out_valid=0. Each accepted byte is stored into group byte slot byte_cnt (0..4), then byte_cnt++. On acceptance of slot 4: byte_cnt->0, go EMIT0.
  - EMIT0: in_ready=0, out_valid=1, out_coeff=GAMMA1-t0, out_idx=coeff_cnt. On transfer: coeff_cnt++, go EMIT1.
  - EMIT1: in_ready=0, out_valid=1, out_coeff=GAMMA1-t1, out_idx=coeff_cnt, out_last=(coeff_cnt==255). On transfer: coeff_cnt++ (wraps 255->0), go COLLECT.
- Field extraction (bytes b0..b4 of group):
  - t0 = {b2[3:0], b1, b0}
  - t1 = {b4, b3, b2[7:4]}
  - Both 20-bit, zero-extended to 32 bits.
- Arithmetic:
  - out_coeff = GAMMA1 - t, 32-bit wrap-around subtraction.
  - Result range -524287..524288. No saturation, no range check.
- Latency and throughput:
  - out_valid rises the cycle after the 5th byte of a group is accepted.
  - Best case 7 cycles per 2 coefficients (5 in, 2 out). No input/output overlap.
- Polynomial framing:
  - After 128 groups (640 bytes), coeff_cnt has wrapped to 0.
  - The next byte starts a new polynomial with no gap or idle cycle required.
- Boundary conditions:
  - in_valid low mid-group: group register and byte_cnt hold indefinitely.
  - out_ready low in EMIT0/EMIT1: state and outputs hold. No byte is accepted (in_ready=0), so no data is lost.
  - Reset mid-group or mid-emit: partial group and pending coefficients are discarded. Counters return to 0 and the next byte is treated as b0 of coefficient 0.
  - in_data with in_valid low: ignored.

Test Plan:
- Bytes 00 00 00 00 00 -> two coefficients 524288 (0x00080000), out_idx 0 then 1, out_last=0.
- Bytes 00 00 08 00 80 -> t0=t1=0x80000 -> out_coeff 0, 0.
- Bytes FF FF FF FF FF -> out_coeff 0xFFF80001 (-524287) twice. Bytes 01 00 10 00 00 -> t0=1, t1=1 -> 524287, 524287.
- Full 640-byte random polynomial (coeffs in -524287..524288, packed by the team's encoder) -> all 256 decoded values equal the originals. out_last only on idx 255. A second back-to-back polynomial restarts at idx 0.
- Random in_valid gaps and out_ready stalls (~30%/~50% duty) -> identical coefficient sequence. Outputs are stable during stalls. in_ready=0 throughout EMIT0/EMIT1.
- Assert rst after 3 bytes, and separately during a stalled EMIT1 -> out_valid drops immediately. After release, 00 00 08 00 80 decodes as idx 0, 1 values 0, 0.
